// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: op encoding, FSM state codes, default width.
// Pure declarations, no timing or flow control of its own.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = MD_WIDTH;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_t;

  typedef logic [1:0] md_state_t;
  localparam md_state_t ST_IDLE = 2'd0;
  localparam md_state_t ST_CALC = 2'd1;
  localparam md_state_t ST_FIX  = 2'd2;
  localparam md_state_t ST_DONE = 2'd3;

  function automatic logic op_is_div(input md_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(input md_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic op_a_signed(input md_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input md_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the 2*WIDTH working register: shift-add multiply or restoring divide.
// Purely combinational, zero latency; the sequencer decides when to apply it.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] work_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] work_out
);

  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;

  always_comb begin
    addend   = work_in[0] ? {1'b0, operand} : '0;
    add_sum  = {1'b0, work_in[2*WIDTH-1:WIDTH]} + addend;
    // Partial remainder shifted left with the next dividend bit, minus the divisor.
    sub_diff = work_in[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    work_out = '0;
    if (is_div) begin
      if (sub_diff[WIDTH]) begin
        work_out = {work_in[2*WIDTH-2:0], 1'b0};
      end else begin
        work_out = {sub_diff[WIDTH-1:0], work_in[WIDTH-2:0], 1'b1};
      end
    end else begin
      work_out = {add_sum, work_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M mul/div for the E stage: DoneE at t+WIDTH+2 (t+2 for trivial operands under MULDIV_FAST_EN).
// Stalls the pipeline through combinational BusyE; the one-cycle result has no backpressure.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StartE,
  input  logic [2:0]       MulDivOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             FlushE,
  output logic             BusyE,
  output logic             DoneE,
  output logic [WIDTH-1:0] MDResultE
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_t          state_q, state_d;
  md_op_t             op_q, op_d;
  logic [2*WIDTH-1:0] work_q, work_d, step_out;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_q, neg_d;
  logic               div0_q, div0_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;

  md_op_t             start_op;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               step_is_div;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

`ifdef MULDIV_FAST_EN
  logic               fast_q, fast_d, fast_hit;
  logic [WIDTH-1:0]   fast_res_q, fast_res_d, fast_val;
`endif

  always_comb begin
    start_op = md_op_t'(MulDivOpE);
    sign_a   = op_a_signed(start_op) & SrcAE[WIDTH-1];
    sign_b   = op_b_signed(start_op) & SrcBE[WIDTH-1];
    mag_a    = sign_a ? -SrcAE : SrcAE;
    mag_b    = sign_b ? -SrcBE : SrcBE;
  end

`ifdef MULDIV_FAST_EN
  // Results that need no iteration: x/0, INT_MIN/-1 and multiply by zero.
  always_comb begin
    fast_hit = 1'b0;
    fast_val = '0;
    if (op_is_div(start_op)) begin
      if (SrcBE == '0) begin
        fast_hit = 1'b1;
        fast_val = op_is_rem(start_op) ? SrcAE : '1;
      end else if (op_a_signed(start_op) && (SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (SrcBE == '1)) begin
        fast_hit = 1'b1;
        fast_val = op_is_rem(start_op) ? '0 : SrcAE;
      end
    end else if ((SrcAE == '0) || (SrcBE == '0)) begin
      fast_hit = 1'b1;
    end
  end
`endif

  assign step_is_div = op_is_div(op_q);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (step_is_div),
    .work_in  (work_q),
    .operand  (opb_q),
    .work_out (step_out)
  );

  always_comb begin
    prod_fix = neg_q ? -work_q : work_q;
    quo_fix  = neg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    rem_fix  = neg_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
    fix_res  = '0;
    case (op_q)
      OP_MUL:                       fix_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      // The magnitude loop yields all-ones for x/0, but the sign fix-up would spoil it.
      OP_DIV, OP_DIVU:              fix_res = div0_q ? '1 : quo_fix;
      default:                      fix_res = rem_fix;
    endcase
`ifdef MULDIV_FAST_EN
    if (fast_q) fix_res = fast_res_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    div0_d  = div0_q;
    cnt_d   = cnt_q;
    res_d   = '0;
`ifdef MULDIV_FAST_EN
    fast_d     = fast_q;
    fast_res_d = fast_res_q;
`endif
    if (FlushE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (StartE) begin
            op_d    = start_op;
            work_d  = {{WIDTH{1'b0}}, mag_a};
            opb_d   = mag_b;
            neg_d   = op_is_rem(start_op) ? sign_a : (sign_a ^ sign_b);
            div0_d  = op_is_div(start_op) && (SrcBE == '0);
            cnt_d   = '0;
            state_d = ST_CALC;
`ifdef MULDIV_FAST_EN
            fast_d     = fast_hit;
            fast_res_d = fast_val;
            if (fast_hit) state_d = ST_FIX;
`endif
          end
        end
        ST_CALC: begin
          work_d = step_out;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = ST_FIX;
        end
        ST_FIX: begin
          res_d   = fix_res;
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      work_q  <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      div0_q  <= div0_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

`ifdef MULDIV_FAST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fast_q     <= 1'b0;
      fast_res_q <= '0;
    end else begin
      fast_q     <= fast_d;
      fast_res_q <= fast_res_d;
    end
  end
`endif

  // DONE drops BusyE so the pipeline advances past the completing instruction.
  assign BusyE     = (state_q == ST_CALC) || (state_q == ST_FIX) ||
                     ((state_q == ST_IDLE) && StartE && !FlushE);
  assign DoneE     = (state_q == ST_DONE) && !FlushE;
  assign MDResultE = DoneE ? res_q : '0;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: arithmetic reference model, directed and random ops.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StartE;
  logic [2:0]  MulDivOpE;
  logic [31:0] SrcAE, SrcBE;
  logic        FlushE;
  logic        BusyE, DoneE;
  logic [31:0] MDResultE;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StartE    (StartE),
    .MulDivOpE (MulDivOpE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .FlushE    (FlushE),
    .BusyE     (BusyE),
    .DoneE     (DoneE),
    .MDResultE (MDResultE)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; p = 64'(q); return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; p = 64'(q); return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_EN
    if (op >= 3'd4 && b == 32'd0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    if (op < 3'd4 && (a == 32'd0 || b == 32'd0)) return 2;
`endif
    return 34;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res);
    int   n;
    exp_t e;
    MulDivOpE = op;
    SrcAE     = a;
    SrcBE     = b;
    StartE    = 1'b1;
    e.res  = res;
    e.cyc  = cyc + exp_lat(op, a, b);
    e.name = name;
    exp_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!DoneE && n < 100) begin
      check({name, "_busy"}, 64'(BusyE), 64'd1);
      n++;
      @(negedge clk);
    end
    if (!DoneE) begin
      n_checks++;
      $display("FAIL %s_timeout: no DoneE within 100 cycles, expected one", name);
      exp_q.delete();
    end else begin
      check({name, "_busy_at_done"}, 64'(BusyE), 64'd0);
    end
    tick();
    StartE = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every DoneE, checks idle-zero result otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (DoneE) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: DoneE with result %0h, expected no completion", MDResultE);
          end else begin
            e = exp_q.pop_front();
            check({e.name, "_result"}, 64'(MDResultE), 64'(e.res));
            check({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
          end
        end else begin
          check("idle_result_zero", 64'(MDResultE), 64'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [2:0]  op;
    logic [31:0] a, b;
    rst_n = 1'b0; StartE = 1'b0; FlushE = 1'b0; MulDivOpE = 3'd0; SrcAE = '0; SrcBE = '0;
    repeat (3) begin
      @(negedge clk);
      check("reset_busy", 64'(BusyE), 64'd0);
      check("reset_done", 64'(DoneE), 64'd0);
      check("reset_result", 64'(MDResultE), 64'd0);
    end
    tick();
    rst_n = 1'b1;
    tick();

    run_op("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulhu_ones",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulh_ones",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("mulhsu_m1_2",  3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
    run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op("divu_7_0",     3'd5, 32'd7,          32'd0,         32'hFFFF_FFFF);
    run_op("remu_7_0",     3'd7, 32'd7,          32'd0,         32'd7);
    run_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("div_m7_0",     3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    run_op("rem_m7_0",     3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
    run_op("mul_zero",     3'd0, 32'd0,          32'd12345,     32'd0);

    // Flush a DIVU mid-iteration, then start a MUL two cycles later.
    t0 = cyc;
    MulDivOpE = 3'd5; SrcAE = 32'd1000; SrcBE = 32'd7; StartE = 1'b1;
    while (cyc < t0 + 10) tick();
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0; StartE = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(BusyE), 64'd0);
    check("flush_done", 64'(DoneE), 64'd0);
    tick();
    check("flush_restart_cycle", 64'(cyc), 64'(t0 + 12));
    run_op("mul_after_flush", 3'd0, 32'd12345, 32'd678, 32'd8369910);

    // Asynchronous reset in the middle of CALC.
    MulDivOpE = 3'd0; SrcAE = 32'd5; SrcBE = 32'd9; StartE = 1'b1;
    repeat (6) tick();
    #1;
    rst_n = 1'b0; StartE = 1'b0;
    #1;
    check("async_rst_busy", 64'(BusyE), 64'd0);
    check("async_rst_done", 64'(DoneE), 64'd0);
    check("async_rst_result", 64'(MDResultE), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_busy", 64'(BusyE), 64'd0);
      check("post_rst_done", 64'(DoneE), 64'd0);
    end
    tick();

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       a = 32'd0;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'h8000_0000;
        3:       a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, ref_md(op, a, b));
    end

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide engine and controller attached to the execute stage, alongside the single-cycle ALU.
- Accepts an M-extension op from the E stage and holds the pipeline with a busy stall while it runs a radix-2 shift-add or shift-subtract loop.
- Presents the 32-bit result for exactly one cycle, which the E stage muxes into ALUResultE.
- Also handles the RISC-V sign fix-up and the architectural special cases.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- StartE  input  1  M-op present in E stage; held high by the pipeline while stalled
- MulDivOpE  input  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- SrcAE  input  WIDTH  rs1 value (forwarded)
- SrcBE  input  WIDTH  rs2 value (forwarded)
- FlushE  input  1  squash the E-stage instruction (branch/jump redirect)
- BusyE  output  1  stall request to the hazard unit
- DoneE  output  1  result valid this cycle
- MDResultE  output  WIDTH  result; 0 when DoneE=0

Behaviour:
- States: IDLE, CALC, FIX, DONE. Reset (async, rst_n=0) forces IDLE and clears all datapath registers, the counter and the op latch. BusyE=0, DoneE=0, MDResultE=0.
- IDLE:
  - StartE=1 and FlushE=0 → latch op, operand magnitudes, the sign flags and the result-negate flag; counter=0; go to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - One iteration per cycle. Counter increments; after WIDTH iterations (counter==WIDTH-1 this cycle) go to FIX.
  - Multiply: 2*WIDTH product register, shift-add on the unsigned magnitudes.
  - Divide: restoring shift-subtract; quotient and remainder held in a 2*WIDTH register.
- FIX: apply the negation, select the low/high half or quotient/remainder, and register MDResultE; go to DONE.
- DONE:
  - DoneE=1 and MDResultE is valid; the next state is always IDLE.
  - StartE is ignored in DONE because it still belongs to the completing instruction.
  - MDResultE returns to 0 in IDLE.
- BusyE = (state==CALC or FIX) or (state==IDLE and StartE and not FlushE). It is combinational so the stall takes effect on the start cycle; BusyE=0 in DONE so the pipeline advances.
- Latency: start in cycle t → DoneE in cycle t+WIDTH+2 (t+34 for WIDTH=32).
- FlushE=1 in any state → next state IDLE, with DoneE suppressed that cycle. A flush coincident with the last CALC iteration still aborts.
- Signedness:
  - MULH and DIV/REM treat both operands as signed; MULHSU treats A as signed and B as unsigned; MULHU, DIVU and REMU treat both as unsigned.
  - A product is negated when the operand signs differ.
  - A quotient is negated when the signs differ; a remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones, remainder = SrcA.
- Signed overflow (DIV of 0x80000000 by -1): quotient 0x80000000, remainder 0.
- Without the optional feature, both special cases fall out of the full iteration plus fix-up; FIX overrides the result where the loop does not produce it.
- MUL returns the low half; MULH, MULHSU and MULHU return the high half.

Optional Feature:
- Macro MULDIV_FAST_EN.
- Defined: in IDLE, divide by zero, signed overflow, or either multiply operand equal to 0 skips CALC and goes directly to FIX with the result forced; DoneE arrives at t+2.
- Undefined: every op takes the fixed WIDTH+2 latency; results are identical.

Decomposition:
- Package muldiv_pkg:
  - op encoding enum md_op_t (3 bits, values as above)
  - state enum md_state_t
  - localparam MD_ITER = WIDTH
- One sub-module, muldiv_step, combinational:
  - performs one shift-add or one shift-subtract step on the 2*WIDTH working register
  - instantiated once by the sequencer, which holds the FSM, the counter and the sign handling

Test Plan:
- MUL, A=7, B=-3 (0xFFFFFFFD), StartE held → BusyE high for cycles t..t+33, DoneE at t+34, MDResultE=0xFFFFFFEB.
- MULHU, A=B=0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU, A=-1, B=2 → 0xFFFFFFFF.
- DIV, A=-7, B=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU, A=7, B=0 → 0xFFFFFFFF. REMU, A=7, B=0 → 7.
- DIV, A=0x80000000, B=0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
  - MULDIV_FAST_EN defined: DoneE at t+2.
  - Undefined: DoneE at t+34.
- FlushE pulsed at cycle t+10 of a DIVU → IDLE next cycle, BusyE=0, no DoneE. A new MUL started at t+12 completes at t+46 with the correct result.
- rst_n asserted low mid-CALC (asynchronously, between edges) → BusyE, DoneE and MDResultE go to 0 immediately; after release, StartE=0 keeps the block in IDLE.
